// File: rtl/bm_dag3_rr_sched.sv
// Round-robin scheduler in front of a shared, fixed-latency 2-bit ALU pipeline.
// Requests are granted one per cycle, travel LAT stages tagged with the
// requester ID, and leave through a valid/ready response port. An
// IDLE/RUN/DRAIN state machine lets control logic quiesce the datapath.
//
// Handshake: resp_valid/resp_id/resp_data are held stable while
// resp_valid=1 and resp_ready=0. A response transfers on any clock edge
// where resp_valid and resp_ready are both 1. While a response is stuck,
// every pipeline stage holds and no grant is issued.
module bm_dag3_rr_sched #(
  parameter int BITS = 2,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [BITS*NREQ-1:0] opa,
  input  logic [BITS*NREQ-1:0] opb,
  output logic [NREQ-1:0]      gnt,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_id,
  output logic [BITS-1:0]      resp_data,
  output logic                 busy,
  output logic [7:0]           done_cnt,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic [LAT-1:0]  st_v;
  logic [1:0]      st_id [LAT];
  logic [1:0]      st_op [LAT];
  logic [BITS-1:0] st_a  [LAT];
  logic [BITS-1:0] st_b  [LAT];

  logic            stall;
  logic            found;
  logic            issue;
  logic [1:0]      win;

  assign resp_valid = st_v[LAT-1];
  assign resp_id    = st_id[LAT-1];
  assign stall      = resp_valid & ~resp_ready;
  assign issue      = (state == RUN) && !stall && found;
  assign busy       = (state != IDLE) || (|st_v);
  assign state_dbg  = state;

  // Round-robin search: first requester above the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[2'((int'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        win   = 2'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // One-hot grant to the search winner when an issue is allowed this cycle.
  always_comb begin
    gnt = '0;
    if (issue) gnt[win] = 1'b1;
  end

  // Result of the operation sitting in the last stage.
  always_comb begin
    case (st_op[LAT-1])
      2'b00:   resp_data = st_a[LAT-1] & st_b[LAT-1];
      2'b01:   resp_data = st_a[LAT-1] | st_b[LAT-1];
      2'b10:   resp_data = st_a[LAT-1] ^ st_b[LAT-1];
      default: resp_data = st_a[LAT-1] - st_b[LAT-1];
    endcase
  end

  // Pipeline shifts as one unit whenever the output is not stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        st_id[k] <= '0;
        st_op[k] <= '0;
        st_a[k]  <= '0;
        st_b[k]  <= '0;
      end
    end else if (!stall) begin
      st_v[0]  <= issue;
      st_id[0] <= win;
      st_op[0] <= op[2*int'(win) +: 2];
      st_a[0]  <= opa[BITS*int'(win) +: BITS];
      st_b[0]  <= opb[BITS*int'(win) +: BITS];
      for (int k = 1; k < LAT; k++) begin
        st_v[k]  <= st_v[k-1];
        st_id[k] <= st_id[k-1];
        st_op[k] <= st_op[k-1];
        st_a[k]  <= st_a[k-1];
        st_b[k]  <= st_b[k-1];
      end
    end
  end

  // Control FSM plus the round-robin pointer it gates.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= 2'(NREQ - 1);
    end else begin
      if (issue) ptr <= win;
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN: begin
          if (en)              state <= RUN;
          else if (st_v == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accepted-response counter, wraps naturally at 8 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) done_cnt <= '0;
    else if (resp_valid && resp_ready) done_cnt <= done_cnt + 8'd1;
  end

endmodule
